// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control definitions: opcodes, ALU and PC-mux select codes, the
// injected NOP, and a writeback-enable helper used by the hazard logic.
package rv_ctrl_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'h03,
        OPC_OP_IMM = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F,
        OPC_SYSTEM = 7'h73
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_e;

    typedef enum logic [1:0] {
        PCSEL_IMM_FD  = 2'd0,
        PCSEL_ALU     = 2'd1,
        PCSEL_PC4     = 2'd2,
        PCSEL_RECOVER = 2'd3
    } pcsel_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [1:0]  BHT_INIT = 2'b01;

    // CSR ops live under SYSTEM; x0 destinations never count as a write.
    function automatic logic writes_rd(input logic [31:0] inst);
        logic op_ok;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: op_ok = 1'b1;
            default:                                   op_ok = 1'b0;
        endcase
        return op_ok && (inst[11:7] != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> control bundle for the 3-stage pipeline; master is the datapath
// side, slave is pipe_ctrl.
interface pipe_ctrl_if;
    logic [31:0] inst_fd;
    logic [31:0] pc_fd;
    logic [31:0] pc_x;
    logic        stall_in;
    logic        breq;
    logic        brlt;
    logic [1:0]  pc_sel;
    logic        flush_fd;
    logic        stall;
    logic [31:0] inst_x;
    logic [31:0] inst_mw;
    logic        wb2d_a;
    logic        wb2d_b;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic        fwd_rs2_x;
    logic        brun;
    logic [3:0]  alu_sel;

    modport master (
        output inst_fd, pc_fd, pc_x, stall_in, breq, brlt,
        input  pc_sel, flush_fd, stall, inst_x, inst_mw, wb2d_a, wb2d_b,
               asel, bsel, fwd_rs2_x, brun, alu_sel
    );

    modport slave (
        input  inst_fd, pc_fd, pc_x, stall_in, breq, brlt,
        output pc_sel, flush_fd, stall, inst_x, inst_mw, wb2d_a, wb2d_b,
               asel, bsel, fwd_rs2_x, brun, alu_sel
    );
endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters; the read port sees the
// pre-update value when it hits the entry being written this cycle.
module bht_2bit #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_taken,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_taken
);
    import rv_ctrl_pkg::*;

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d [DEPTH];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            if (wr_taken && cnt_q[wr_idx] != 2'b11) begin
                cnt_d[wr_idx] = cnt_q[wr_idx] + 2'd1;
            end else if (!wr_taken && cnt_q[wr_idx] != 2'b00) begin
                cnt_d[wr_idx] = cnt_q[wr_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= BHT_INIT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/pipe_ctrl.sv
// Control/hazard unit for the FD -> X -> MW RV32I pipeline: X/MW instruction
// registers, X decode, WB forwarding selects and predicted branch resolution.
module pipe_ctrl #(
    parameter int unsigned BHT_DEPTH  = 16,
    parameter bit          PREDICT_EN = 1'b1,
    parameter logic [31:0] NOP_INST   = rv_ctrl_pkg::NOP_INST
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    import rv_ctrl_pkg::*;

    localparam int unsigned IW = $clog2(BHT_DEPTH);

    logic [31:0] inst_x_q, inst_x_d;
    logic [31:0] inst_mw_q, inst_mw_d;
    logic        pred_x_q, pred_x_d;

    logic [6:0] op_fd, op_x;
    logic [4:0] rs1_fd, rs2_fd, rs1_x, rs2_x, rd_mw;
    logic [2:0] f3_x;
    logic       f7b5_x;
    logic       wb_en_mw, fwd_a_x, fwd_b_x;
    logic       x_branch, taken_x, pred_fd, bht_taken, redirect_x;
    alu_e       alu_sel;
    pcsel_e     pc_sel;
    logic [1:0] asel, bsel;
    logic       unused_bits;

    assign op_fd  = bus.inst_fd[6:0];
    assign rs1_fd = bus.inst_fd[19:15];
    assign rs2_fd = bus.inst_fd[24:20];
    assign op_x   = inst_x_q[6:0];
    assign f3_x   = inst_x_q[14:12];
    assign f7b5_x = inst_x_q[30];
    assign rs1_x  = inst_x_q[19:15];
    assign rs2_x  = inst_x_q[24:20];
    assign rd_mw  = inst_mw_q[11:7];

    assign wb_en_mw = writes_rd(inst_mw_q);
    assign fwd_a_x  = wb_en_mw && (rd_mw == rs1_x);
    assign fwd_b_x  = wb_en_mw && (rd_mw == rs2_x);
    assign x_branch = (op_x == OPC_BRANCH);

    bht_2bit #(.DEPTH(BHT_DEPTH)) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (bus.pc_fd[2 +: IW]),
        .rd_taken (bht_taken),
        .wr_en    (x_branch && !bus.stall_in),
        .wr_idx   (bus.pc_x[2 +: IW]),
        .wr_taken (taken_x)
    );

    always_comb begin
        alu_sel = ALU_ADD;
        case (op_x)
            OPC_LUI: alu_sel = ALU_PASS_B;
            OPC_OP, OPC_OP_IMM: begin
                case (f3_x)
                    3'b000:  alu_sel = (op_x == OPC_OP && f7b5_x) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_sel = ALU_SLL;
                    3'b010:  alu_sel = ALU_SLT;
                    3'b011:  alu_sel = ALU_SLTU;
                    3'b100:  alu_sel = ALU_XOR;
                    3'b101:  alu_sel = f7b5_x ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_sel = ALU_OR;
                    default: alu_sel = ALU_AND;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

    always_comb begin
        taken_x = 1'b0;
        if (x_branch) begin
            case (f3_x)
                3'b000:          taken_x = bus.breq;
                3'b001:          taken_x = !bus.breq;
                3'b100, 3'b110:  taken_x = bus.brlt;
                3'b101, 3'b111:  taken_x = !bus.brlt;
                default:         taken_x = 1'b0;
            endcase
        end
    end

    always_comb begin
        asel = 2'd0;
        if (op_x == OPC_AUIPC || op_x == OPC_JAL || x_branch) begin
            asel = 2'd1;
        end else if (fwd_a_x) begin
            asel = 2'd2;
        end
        bsel = 2'd1;
        if (op_x == OPC_OP) begin
            bsel = fwd_b_x ? 2'd2 : 2'd0;
        end
    end

    // A resolved X redirect outranks any FD-stage jump or prediction.
    always_comb begin
        pred_fd = PREDICT_EN && (op_fd == OPC_BRANCH) && bht_taken;
        pc_sel  = PCSEL_PC4;
        if (op_x == OPC_JALR || (x_branch && taken_x && !pred_x_q)) begin
            pc_sel = PCSEL_ALU;
        end else if (x_branch && !taken_x && pred_x_q) begin
            pc_sel = PCSEL_RECOVER;
        end else if (op_fd == OPC_JAL || pred_fd) begin
            pc_sel = PCSEL_IMM_FD;
        end
        redirect_x = (pc_sel == PCSEL_ALU) || (pc_sel == PCSEL_RECOVER);
    end

    always_comb begin
        inst_x_d  = inst_x_q;
        inst_mw_d = inst_mw_q;
        pred_x_d  = pred_x_q;
        if (!bus.stall_in) begin
            inst_mw_d = inst_x_q;
            inst_x_d  = redirect_x ? NOP_INST : bus.inst_fd;
            pred_x_d  = pred_fd && !redirect_x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_x_q  <= NOP_INST;
            inst_mw_q <= NOP_INST;
            pred_x_q  <= 1'b0;
        end else begin
            inst_x_q  <= inst_x_d;
            inst_mw_q <= inst_mw_d;
            pred_x_q  <= pred_x_d;
        end
    end

    assign bus.pc_sel    = pc_sel;
    assign bus.flush_fd  = redirect_x;
    assign bus.stall     = bus.stall_in;
    assign bus.inst_x    = inst_x_q;
    assign bus.inst_mw   = inst_mw_q;
    assign bus.wb2d_a    = wb_en_mw && (rd_mw == rs1_fd);
    assign bus.wb2d_b    = wb_en_mw && (rd_mw == rs2_fd);
    assign bus.asel      = asel;
    assign bus.bsel      = bsel;
    assign bus.fwd_rs2_x = fwd_b_x && (x_branch || op_x == OPC_STORE);
    assign bus.brun      = x_branch && (f3_x[2:1] == 2'b11);
    assign bus.alu_sel   = alu_sel;

    assign unused_bits = ^{bus.inst_fd, bus.pc_fd, bus.pc_x, inst_mw_q};

endmodule
